ahblite_interconnect_n: RTL
===========================

Name: ahblite_interconnect_n

Overview:
- Parametrised AHB-Lite single-master interconnect: one bus from cortexm0ds_logic fans out to NUM_SLAVES slave ports.
- Address-phase decode on HADDR[31:28], registered data-phase response mux, and a built-in default slave that returns a two-cycle ERROR for unmapped addresses.
- Captures the first unmapped-access address for debug/firmware inspection.
- Replaces the fixed 4-port interconnect in CortexM0_SoC so that UART, timer and similar slaves can be added without new RTL.

Parameters:
- NUM_SLAVES, 4, number of slave ports, 1..15.
- DATA_W, 32, HWDATA/HRDATA width.
- SLV_BASE, {4'h5,4'h4,4'h2,4'h0}, NUM_SLAVES×4-bit vector; nibble i = HADDR[31:28] value decoded to slave i.
- ERRCNT_W, 8, width of the saturating unmapped-access counter.

Ports:
- HCLK  in  1  bus clock (only clock).
- HRESETn  in  1  reset, synchronous, active-low.
- HADDR  in  32  master address.
- HTRANS  in  2  master transfer type.
- HSIZE  in  3  master transfer size.
- HBURST  in  3  master burst type.
- HPROT  in  4  master protection control.
- HMASTLOCK  in  1  master lock.
- HWRITE  in  1  master write flag.
- HWDATA  in  DATA_W  master write data.
- HRDATA  out  DATA_W  muxed read data to master.
- HREADY  out  1  muxed ready to master; also broadcast to slaves.
- HRESP  out  1  muxed response to master.
- HSEL_S  out  NUM_SLAVES  per-slave select, one-hot or zero.
- HADDR_S, HTRANS_S, HSIZE_S, HBURST_S, HPROT_S, HMASTLOCK_S, HWRITE_S, HWDATA_S  out  as master  broadcast copies of master signals.
- HREADYOUT_S  in  NUM_SLAVES  per-slave ready.
- HRDATA_S  in  NUM_SLAVES×DATA_W  per-slave read data; slave i occupies bits [i*DATA_W +: DATA_W].
- HRESP_S  in  NUM_SLAVES  per-slave response.
- ERR_VALID  out  1  sticky flag: an unmapped access occurred.
- ERR_ADDR  out  32  address of the first captured unmapped access.
- ERR_WRITE  out  1  HWRITE of the captured access.
- ERR_COUNT  out  ERRCNT_W  saturating count of unmapped accesses.
- ERR_CLR  in  1  clears ERR_VALID, ERR_ADDR, ERR_WRITE and ERR_COUNT.

Behaviour:
- All state updates on HCLK rising edge. HRESETn low at an edge resets all state, including mid-transfer.
- Decode (combinational):
  - match[i] = (HADDR[31:28] == SLV_BASE[i]).
  - Overlapping bases: lowest index wins.
  - No match: the internal default slave D is selected.
  - HSEL_S is independent of HTRANS; slaves qualify with HTRANS[1] & HREADY.
- Data-phase select dsel (one-hot, NUM_SLAVES+1 bits):
  - Loads the decode result when HREADY=1; holds otherwise.
  - Reset value: D selected.
- Response mux:
  - HREADY, HRESP and HRDATA come from the slave selected by dsel.
  - When D is selected, HRDATA = 0.
- Default slave FSM, states IDLE, ERR1, ERR2:
  - IDLE: HREADYOUT_D=1, HRESP_D=0. Moves to ERR1 if D is decoded, HTRANS[1]=1 and HREADY=1.
  - ERR1: HREADYOUT_D=0, HRESP_D=1. Always moves to ERR2.
  - ERR2: HREADYOUT_D=1, HRESP_D=1. Moves to ERR1 if another unmapped NONSEQ/SEQ is accepted this cycle, else IDLE.
  - IDLE/BUSY to unmapped space: zero-wait OKAY.
- Reset values: FSM=IDLE, so HREADY=1, HRESP=0, HRDATA=0 after reset.
- Error capture:
  - On each transition into ERR1: ERR_COUNT += 1, saturating at all-ones.
  - If ERR_VALID=0 at that point: latch HADDR to ERR_ADDR and HWRITE to ERR_WRITE, set ERR_VALID. If ERR_VALID=1, ERR_ADDR/ERR_WRITE hold.
  - ERR_CLR=1 zeroes all error outputs.
  - ERR_CLR and an ERR1 entry in the same cycle: the capture wins; result ERR_VALID=1, ERR_COUNT=1, new address latched.
  - Reset value of all error outputs: 0.
- Latency: zero added cycles; HREADY path is combinational from HREADYOUT_S.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS codes IDLE/BUSY/NONSEQ/SEQ.
  - HRESP codes OKAY/ERROR.
  - Default SoC map constants: CODE 0x0, DATA 0x2, WATERLIGHT 0x4, UART 0x5.
  - Default-slave state enum.
- Sub-module ahblite_default_slave: FSM plus HREADYOUT_D/HRESP_D; instantiated once.

Test Plan:
- Reset, then NONSEQ read of 0x2000_0010 with slave1 returning 0xDEAD_BEEF zero-wait -> HSEL_S=4'b0010 in the address phase; HRDATA=0xDEAD_BEEF, HREADY=1, HRESP=0 next cycle.
- Slave2 holds HREADYOUT low for 3 cycles on a write to 0x4000_0000, with a following NONSEQ to 0x0000_0000 -> HREADY low 3 cycles; dsel stays at slave2; slave0 data phase begins only after HREADY=1.
- NONSEQ write to 0x9000_0004 (unmapped) -> one cycle HREADY=0/HRESP=1, then HREADY=1/HRESP=1; ERR_VALID=1, ERR_ADDR=0x9000_0004, ERR_WRITE=1, ERR_COUNT=1.
- Back-to-back unmapped reads 0x9000_0000 then 0xA000_0000 (second accepted during ERR2) -> ERR2→ERR1 directly; ERR_ADDR stays 0x9000_0000; ERR_COUNT=2.
- IDLE transfer to 0xF000_0000 -> HREADY=1, HRESP=0, no ERR_VALID; with ERRCNT_W=2 and 5 errors -> ERR_COUNT=3; ERR_CLR coincident with a new error -> ERR_COUNT=1, ERR_VALID=1.
- HRESETn driven low during ERR1 -> at the next edge FSM=IDLE, HREADY=1, HRESP=0, all error outputs 0.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, the default SoC address map nibbles, and the
// default-slave state type used by the interconnect.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [3:0] MAP_CODE       = 4'h0;
    localparam logic [3:0] MAP_DATA       = 4'h2;
    localparam logic [3:0] MAP_WATERLIGHT = 4'h4;
    localparam logic [3:0] MAP_UART       = 4'h5;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } dslave_state_e;

endpackage

// File: rtl/ahblite_default_slave.sv
// Built-in default slave: answers unmapped NONSEQ/SEQ transfers with the
// two-cycle AHB ERROR response and flags each new error entry.
module ahblite_default_slave
    import ahb_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       sel_d,
    input  logic [1:0] HTRANS,
    input  logic       HREADY,
    output logic       HREADYOUT_D,
    output logic       HRESP_D,
    output logic       err_start
);

    dslave_state_e state;
    dslave_state_e state_next;
    logic          accept;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state <= DS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs depend on state only, so HREADY never loops back through them.
    assign HREADYOUT_D = (state != DS_ERR1);
    assign HRESP_D     = (state == DS_IDLE) ? HRESP_OKAY : HRESP_ERROR;

    assign accept = sel_d & HTRANS[1] & HREADY;

    always_comb begin
        state_next = state;
        err_start  = 1'b0;
        case (state)
            DS_IDLE: begin
                if (accept) begin
                    state_next = DS_ERR1;
                    err_start  = 1'b1;
                end
            end
            DS_ERR1: begin
                state_next = DS_ERR2;
            end
            DS_ERR2: begin
                if (accept) begin
                    state_next = DS_ERR1;
                    err_start  = 1'b1;
                end else begin
                    state_next = DS_IDLE;
                end
            end
            default: begin
                state_next = DS_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/ahblite_interconnect_n.sv
// Single-master AHB-Lite interconnect: HADDR[31:28] decode to NUM_SLAVES ports,
// registered data-phase response mux, default ERROR slave and unmapped-access capture.
module ahblite_interconnect_n
    import ahb_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int DATA_W     = 32,
    parameter logic [NUM_SLAVES*4-1:0] SLV_BASE = {MAP_UART, MAP_WATERLIGHT, MAP_DATA, MAP_CODE},
    parameter int ERRCNT_W   = 8
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic [31:0]                  HADDR,
    input  logic [1:0]                   HTRANS,
    input  logic [2:0]                   HSIZE,
    input  logic [2:0]                   HBURST,
    input  logic [3:0]                   HPROT,
    input  logic                         HMASTLOCK,
    input  logic                         HWRITE,
    input  logic [DATA_W-1:0]            HWDATA,
    output logic [DATA_W-1:0]            HRDATA,
    output logic                         HREADY,
    output logic                         HRESP,
    output logic [NUM_SLAVES-1:0]        HSEL_S,
    output logic [31:0]                  HADDR_S,
    output logic [1:0]                   HTRANS_S,
    output logic [2:0]                   HSIZE_S,
    output logic [2:0]                   HBURST_S,
    output logic [3:0]                   HPROT_S,
    output logic                         HMASTLOCK_S,
    output logic                         HWRITE_S,
    output logic [DATA_W-1:0]            HWDATA_S,
    input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
    input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
    input  logic [NUM_SLAVES-1:0]        HRESP_S,
    output logic                         ERR_VALID,
    output logic [31:0]                  ERR_ADDR,
    output logic                         ERR_WRITE,
    output logic [ERRCNT_W-1:0]          ERR_COUNT,
    input  logic                         ERR_CLR
);

    localparam int D_IDX = NUM_SLAVES;

    logic [NUM_SLAVES:0]  dec_sel;
    logic [NUM_SLAVES:0]  dsel;
    logic                 dec_hit;
    logic                 hreadyout_d;
    logic                 hresp_d;
    logic                 err_start;
    logic                 hready_mux;
    logic                 hresp_mux;
    logic [DATA_W-1:0]    hrdata_mux;

    // Lowest-index match wins when bases overlap; no match selects the default slave.
    always_comb begin
        dec_sel = '0;
        dec_hit = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!dec_hit && (HADDR[31:28] == SLV_BASE[i*4 +: 4])) begin
                dec_sel[i] = 1'b1;
                dec_hit    = 1'b1;
            end
        end
        dec_sel[D_IDX] = ~dec_hit;
    end

    assign HSEL_S      = dec_sel[NUM_SLAVES-1:0];
    assign HADDR_S     = HADDR;
    assign HTRANS_S    = HTRANS;
    assign HSIZE_S     = HSIZE;
    assign HBURST_S    = HBURST;
    assign HPROT_S     = HPROT;
    assign HMASTLOCK_S = HMASTLOCK;
    assign HWRITE_S    = HWRITE;
    assign HWDATA_S    = HWDATA;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dsel <= {1'b1, {NUM_SLAVES{1'b0}}};
        end else if (HREADY) begin
            dsel <= dec_sel;
        end
    end

    // AND-OR mux is safe because dsel is always one-hot.
    always_comb begin
        hready_mux = dsel[D_IDX] & hreadyout_d;
        hresp_mux  = dsel[D_IDX] & hresp_d;
        hrdata_mux = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            hready_mux = hready_mux | (dsel[i] & HREADYOUT_S[i]);
            hresp_mux  = hresp_mux  | (dsel[i] & HRESP_S[i]);
            hrdata_mux = hrdata_mux | ({DATA_W{dsel[i]}} & HRDATA_S[i*DATA_W +: DATA_W]);
        end
    end

    assign HREADY = hready_mux;
    assign HRESP  = hresp_mux;
    assign HRDATA = hrdata_mux;

    ahblite_default_slave u_default_slave (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .sel_d       (dec_sel[D_IDX]),
        .HTRANS      (HTRANS),
        .HREADY      (HREADY),
        .HREADYOUT_D (hreadyout_d),
        .HRESP_D     (hresp_d),
        .err_start   (err_start)
    );

    // A new error beats a simultaneous clear, restarting the log from this access.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            ERR_VALID <= 1'b0;
            ERR_ADDR  <= '0;
            ERR_WRITE <= 1'b0;
            ERR_COUNT <= '0;
        end else if (err_start) begin
            if (ERR_CLR) begin
                ERR_COUNT <= ERRCNT_W'(1);
            end else if (!(&ERR_COUNT)) begin
                ERR_COUNT <= ERR_COUNT + ERRCNT_W'(1);
            end
            if (!ERR_VALID || ERR_CLR) begin
                ERR_VALID <= 1'b1;
                ERR_ADDR  <= HADDR;
                ERR_WRITE <= HWRITE;
            end
        end else if (ERR_CLR) begin
            ERR_VALID <= 1'b0;
            ERR_ADDR  <= '0;
            ERR_WRITE <= 1'b0;
            ERR_COUNT <= '0;
        end
    end

endmodule
